bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 shifted first, 0 = bit 0 first.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port load_data, input, WIDTH: parallel word to serialize.
REQ-006 SHALL have port load_valid, input, 1: load_data is valid this cycle.
REQ-007 SHALL have port load_ready, output, 1: block can accept a word this cycle.
REQ-008 SHALL have port x, output, 1: serial bit stream to the downstream sequence detector.
REQ-009 SHALL have port x_valid, output, 1: x carries a data bit this cycle.
REQ-010 SHALL have port frame_done, output, 1: one-cycle pulse coincident with the last bit of a word.
REQ-011 SHALL have port busy, output, 1: shift register or hold buffer occupied.

Function
REQ-012 SHALL complete a load transfer only on a rising edge where load_valid=1 and load_ready=1; load_data is ignored otherwise.
REQ-013 SHALL contain a WIDTH-bit shift register, a bit counter of $clog2(WIDTH) bits, and one WIDTH-bit hold buffer with a full flag.
REQ-014 SHALL drive load_ready = NOT hold_full, combinationally from registered state only (no path from load_valid).
REQ-015 SHALL implement two states: IDLE (shift register empty) and SHIFT (shifting a word).
REQ-016 In IDLE, an accepted word SHALL load directly into the shift register (hold buffer untouched) and go to SHIFT; first bit appears on x on the following cycle (latency 1).
REQ-017 In SHIFT, an accepted word SHALL be written into the hold buffer, except on the last-bit cycle with the hold buffer empty, where it loads directly into the shift register.
REQ-018 On the last-bit cycle (counter = WIDTH-1): if a word is pending (hold full or accepted this cycle), SHALL load it, clear the counter, and stay in SHIFT with no idle gap; otherwise go to IDLE.
REQ-019 SHALL register x, x_valid and frame_done: x_valid=1 for exactly WIDTH consecutive cycles per word.
REQ-020 SHALL hold x=0 whenever x_valid=0, so the downstream detector sees zeros between words.
REQ-021 SHALL shift MSB-first or LSB-first per MSB_FIRST; bit order within a word is never altered otherwise.
REQ-022 SHALL assert busy when state=SHIFT or hold_full=1.
REQ-023 Downstream has no backpressure; SHALL never stall mid-word.

Reset
REQ-024 While reset=0 on a rising edge: state=IDLE, counter=0, hold_full=0, shift register=0, x=0, x_valid=0, frame_done=0, busy=0, load_ready=1 on the following cycle.
REQ-025 Reset mid-word SHALL discard the in-flight word and any held word; no partial bits after reset.
REQ-026 A load presented during reset SHALL NOT be accepted.

Structure
REQ-027 SHALL place the IDLE/SHIFT state encoding and the default WIDTH constant in shared package bit_serializer_pkg.
REQ-028 SHALL be a single module with no sub-modules; the bit counter and hold buffer stay inline.

Verification
REQ-029 Reset: hold reset=0 for 2 cycles with load_valid=1 -> x=0, x_valid=0, busy=0, load_ready=1, no word accepted.
REQ-030 Single word 8'hA5, MSB_FIRST=1 -> x = 1,0,1,0,0,1,0,1 over 8 cycles starting 1 cycle after accept; frame_done on the 8th bit only; downstream detector reports "101" twice.
REQ-031 Back-to-back 8'hFF then 8'h00 then 8'h81 with load_valid held high -> 24 contiguous x_valid cycles; load_ready low while hold full; no gap between words.
REQ-032 Load 8'h05 exactly on the last-bit cycle of a prior word with hold empty -> next word's first bit on the very next cycle.
REQ-033 Reset asserted at bit 4 of 8'hA5 with 8'h3C held -> x_valid=0 next cycle; neither word's remaining bits ever appear.
REQ-034 MSB_FIRST=0, word 8'h05 -> x = 1,0,1,0,0,0,0,0.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and default word width.
package bit_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer. Words stream out
// back-to-back with no idle gap whenever the next word is already waiting.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic [WIDTH-1:0]   hold_reg, hold_next;
    logic               hold_full_reg, hold_full_next;
    logic               x_reg, x_next;
    logic               x_valid_reg, x_valid_next;
    logic               frame_done_reg, frame_done_next;

    logic               accept;
    logic               load_now;
    logic               step_now;
    logic [WIDTH-1:0]   load_word;
    logic [WIDTH-1:0]   src_word;

    // Ready depends on registered state only, so there is no valid-to-ready path.
    assign load_ready = ~hold_full_reg;
    assign accept     = load_valid & load_ready;
    assign busy       = (state_reg == SHIFT) | hold_full_reg;
    assign x          = x_reg;
    assign x_valid    = x_valid_reg;
    assign frame_done = frame_done_reg;

    // Next-state logic: decide whether to load a new word, step the current one, or go idle.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        shift_next      = shift_reg;
        hold_next       = hold_reg;
        hold_full_next  = hold_full_reg;
        x_next          = 1'b0;
        x_valid_next    = 1'b0;
        frame_done_next = 1'b0;
        load_now        = 1'b0;
        step_now        = 1'b0;
        load_word       = load_data;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    load_now = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_reg == LAST_CNT) begin
                    // Last bit on the wire: chain the pending word straight in.
                    if (hold_full_reg) begin
                        load_word      = hold_reg;
                        load_now       = 1'b1;
                        hold_full_next = 1'b0;
                    end else if (accept) begin
                        load_now = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    step_now = 1'b1;
                    if (accept) begin
                        hold_next      = load_data;
                        hold_full_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // The leading bit of src_word goes onto x; the rest advance toward the lead position.
        src_word = load_now ? load_word : shift_reg;

        if (load_now || step_now) begin
            x_next       = MSB_FIRST ? src_word[WIDTH-1] : src_word[0];
            shift_next   = MSB_FIRST ? {src_word[WIDTH-2:0], 1'b0}
                                     : {1'b0, src_word[WIDTH-1:1]};
            x_valid_next = 1'b1;
        end

        if (load_now) begin
            state_next      = SHIFT;
            cnt_next        = '0;
            frame_done_next = 1'b0;
        end else if (step_now) begin
            cnt_next        = cnt_reg + 1'b1;
            frame_done_next = (cnt_next == LAST_CNT);
        end
    end

    // State and output registers; active-low reset drops any in-flight and held word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            shift_reg      <= '0;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
            x_reg          <= 1'b0;
            x_valid_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            shift_reg      <= shift_next;
            hold_reg       <= hold_next;
            hold_full_reg  <= hold_full_next;
            x_reg          <= x_next;
            x_valid_reg    <= x_valid_next;
            frame_done_reg <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: accepted words are expanded into expected bit queues, and a
// negedge monitor pops and compares whatever the two serializers (MSB/LSB first) emit.
module tb_bit_serializer;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] load_data;
    logic         load_valid;

    logic ready_m, x_m, xv_m, fd_m, busy_m;
    logic ready_l, x_l, xv_l, fd_l, busy_l;

    exp_t q_msb[$];
    exp_t q_lsb[$];
    logic xhist[$];

    int   tests = 0;
    int   fails = 0;
    bit   armed = 1'b0;
    bit   model_ready = 1'b1;
    int   run_len = 0;
    int   last_run = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(ready_m), .x(x_m), .x_valid(xv_m), .frame_done(fd_m), .busy(busy_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(ready_l), .x(x_l), .x_valid(xv_l), .frame_done(fd_l), .busy(busy_l)
    );

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int count_101();
        int c = 0;
        for (int i = 0; i + 2 < xhist.size(); i++)
            if (xhist[i] == 1'b1 && xhist[i+1] == 1'b0 && xhist[i+2] == 1'b1) c++;
        return c;
    endfunction

    // Reference model: a word is taken on any edge out of reset where valid is high
    // and the model says there is room; it becomes W expected bits in each order.
    always @(posedge clk) begin
        if (!reset) begin
            q_msb.delete();
            q_lsb.delete();
        end else if (load_valid && model_ready) begin
            for (int i = 0; i < W; i++) begin
                q_msb.push_back('{b: load_data[W-1-i], last: (i == W-1)});
                q_lsb.push_back('{b: load_data[i],     last: (i == W-1)});
            end
            $display("[TB] accept word %h at %0t", load_data, $time);
        end
    end

    // Monitor: outstanding bits (including the one on the wire now) define the
    // expected valid/busy, and more than one word outstanding means the hold is full.
    always @(negedge clk) begin
        int   n;
        exp_t e;
        if (armed) begin
            n = q_msb.size();
            check("m_ready",  ready_m, n <= W);
            check("l_ready",  ready_l, n <= W);
            check("m_busy",   busy_m,  n > 0);
            check("l_busy",   busy_l,  n > 0);
            check("m_xvalid", xv_m,    n > 0);
            check("l_xvalid", xv_l,    n > 0);
            if (n > 0) begin
                e = q_msb.pop_front();
                check("m_x",  x_m,  e.b);
                check("m_fd", fd_m, e.last);
                e = q_lsb.pop_front();
                check("l_x",  x_l,  e.b);
                check("l_fd", fd_l, e.last);
            end else begin
                check("m_x_idle",  x_m,  1'b0);
                check("m_fd_idle", fd_m, 1'b0);
                check("l_x_idle",  x_l,  1'b0);
                check("l_fd_idle", fd_l, 1'b0);
            end
            model_ready = (n <= W);
            if (xv_m === 1'b1) begin
                run_len++;
                xhist.push_back(x_m);
            end else if (run_len > 0) begin
                last_run = run_len;
                run_len  = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until the model says an edge accepted it.
    task automatic send(input logic [W-1:0] w);
        int k = 0;
        load_data  = w;
        load_valid = 1'b1;
        forever begin
            @(posedge clk);
            if (model_ready) break;
            k++;
            if (k > 100) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: word %h not accepted within 100 cycles", w);
                break;
            end
        end
        #1;
        load_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int gap;
        reset      = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h77;

        // Reset held for two edges with a word offered: nothing may be accepted.
        @(posedge clk);
        #1;
        armed = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b1;
        load_valid = 1'b0;
        idle(3);

        // Single word: stream order, frame_done on the last bit, detector sees "101" twice.
        xhist.delete();
        send(8'hA5);
        idle(12);
        check_int("a5_run", last_run, 8);
        check_int("a5_101", count_101(), 2);

        // Back-to-back words with valid held high: one unbroken 24-bit run.
        send(8'hFF);
        send(8'h00);
        send(8'h81);
        idle(30);
        check_int("b2b_run", last_run, 24);

        // Word offered exactly on the last-bit cycle with the hold empty.
        send(8'hC3);
        repeat (W-1) @(posedge clk);
        #1;
        send(8'h05);
        idle(20);
        check_int("lastbit_run", last_run, 16);

        // Reset while bit 4 of A5 is on the wire and 3C sits in the hold buffer.
        send(8'hA5);
        send(8'h3C);
        repeat (3) @(posedge clk);
        #1;
        pulse_reset();
        idle(20);

        // LSB-first stream of 05 (checked on dut_lsb through the scoreboard).
        send(8'h05);
        idle(12);
        check_int("lsb05_run", last_run, 8);

        // Random words, random gaps (0 = chained), occasional reset.
        for (int i = 0; i < 150; i++) begin
            send(W'($urandom_range(0, 255)));
            gap = $urandom_range(0, 10);
            if (gap > 6) idle(gap);
            if ($urandom_range(0, 39) == 0) pulse_reset();
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
